// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Request priority lives here so the top and any checker agree on one encoding.
package pc_pkg;

  // Operation selected for the current cycle, after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_UP,
    OP_BR,
    OP_LD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  // Priority encode the raw request bits: Ret > Call > Ld > Br > Up.
  // Lower-priority requests in the same cycle are dropped, not queued.
  function automatic pc_op_e pc_decode(input logic ret,
                                       input logic call,
                                       input logic ld,
                                       input logic br,
                                       input logic up);
    pc_op_e op;
    if (ret) begin
      op = OP_RET;
    end else if (call) begin
      op = OP_CALL;
    end else if (ld) begin
      op = OP_LD;
    end else if (br) begin
      op = OP_BR;
    end else if (up) begin
      op = OP_UP;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the program-counter sequencer.
// DEPTH entries of W bits. A push while full or a pop while empty is
// ignored here; the caller decides how to flag it. Clr empties the stack
// asynchronously; entry contents are left as-is since empty hides them.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  // Status flags, accepted operations and index of the newest entry.
  always_comb begin
    full    = (cnt == CW'(DEPTH));
    empty   = (cnt == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_idx  = IW'(cnt);
    top_idx = IW'(cnt - 1'b1);
    top_data = empty ? '0 : mem[top_idx];
  end

  // Occupancy count; this alone defines which entries are live.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + 1'b1;
    end else if (do_pop) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Entry storage, written at the slot just above the current top.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, absolute jump, signed relative
// branch and, with PC_RET_STACK_EN defined, call/return through an
// internal return stack. Addr feeds the instruction ROM directly.
// Without PC_RET_STACK_EN, Call acts as a plain jump, Ret is ignored and
// StkErr stays 0; the ports stay so the interface never changes.
//
// Request handshake: every request input is a single-cycle level sampled
// on the rising Clk edge; there is no ready/backpressure, exactly one
// request (the highest-priority one) is served per edge, and its effect is
// visible on Addr/Halted/StkErr right after that edge.
module pc_seq
  import pc_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int OFF_W      = 5,
  parameter int RESET_ADDR = 0,
  parameter int WRAP       = 1,
  parameter int STK_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Up,
  input  logic              Ld,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic              Br,
  input  logic [OFF_W-1:0]  BrOff,
  input  logic              Call,
  input  logic              Ret,
  output logic [ADDR_W-1:0] Addr,
  output logic              Halted,
  output logic              StkErr
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(RESET_ADDR);

  pc_op_e            op;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] addr_nx;
  logic              halted_nx;
  logic              ret_req;
  logic              call_req;
  logic              ld_req;

`ifdef PC_RET_STACK_EN
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic              err_set;

  // Return stack holds Addr+1 of each outstanding call.
  pc_ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .Clk       (Clk),
    .Clr       (Clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (Addr + 1'b1),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Request routing with the stack present: all five requests are live.
  always_comb begin
    ret_req  = Ret;
    call_req = Call;
    ld_req   = Ld;
  end
`else
  logic unused_ret;
  logic unused_depth;

  // Request routing without a stack: Call is a plain jump, Ret is dropped.
  always_comb begin
    ret_req      = 1'b0;
    call_req     = 1'b0;
    ld_req       = Ld | Call;
    unused_ret   = Ret;
    unused_depth = (STK_DEPTH > 0);
  end
`endif

  // Decode the request, sign-extend the branch offset, select next state.
  always_comb begin
    op        = pc_decode(ret_req, call_req, ld_req, Br, Up);
    br_ext    = ADDR_W'($signed(BrOff));
    addr_nx   = Addr;
    halted_nx = Halted;
`ifdef PC_RET_STACK_EN
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    err_set   = 1'b0;
`endif
    case (op)
      OP_UP: begin
        // A halted counter ignores Up until something else moves it.
        if (!Halted) begin
          if (Addr != ADDR_MAX) begin
            addr_nx = Addr + 1'b1;
          end else if (WRAP != 0) begin
            addr_nx = '0;
          end else begin
            halted_nx = 1'b1;
          end
        end
      end
      OP_BR: begin
        // Modulo-2**ADDR_W add wraps in both directions.
        addr_nx   = Addr + br_ext;
        halted_nx = 1'b0;
      end
      OP_LD: begin
        addr_nx   = LdAddr;
        halted_nx = 1'b0;
      end
`ifdef PC_RET_STACK_EN
      OP_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        addr_nx   = LdAddr;
        halted_nx = 1'b0;
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
      end
      OP_RET: begin
        halted_nx = 1'b0;
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          addr_nx = stk_top;
          stk_pop = 1'b1;
        end
      end
`endif
      default: begin
        addr_nx   = Addr;
        halted_nx = Halted;
      end
    endcase
  end

  // Address and halt registers; Clr forces them immediately.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      Addr   <= ADDR_RST;
      Halted <= 1'b0;
    end else begin
      Addr   <= addr_nx;
      Halted <= halted_nx;
    end
  end

`ifdef PC_RET_STACK_EN
  // Sticky stack-error flag, cleared only by Clr.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      StkErr <= 1'b0;
    end else if (err_set) begin
      StkErr <= 1'b1;
    end
  end
`else
  // No stack, so no stack error can occur.
  always_comb begin
    StkErr = 1'b0;
  end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: one instance with WRAP=1 (main) and one with
// WRAP=0 (halt behaviour). Call/return checks follow PC_RET_STACK_EN.
module tb_pc_seq;

  localparam int ADDR_W = 7;
  localparam int OFF_W  = 5;

  logic              Clk;
  logic              Clr;
  logic              Up, Ld, Br, Call, Ret;
  logic [ADDR_W-1:0] LdAddr;
  logic [OFF_W-1:0]  BrOff;
  logic [ADDR_W-1:0] Addr;
  logic              Halted, StkErr;

  logic              nw_up, nw_ld;
  logic [ADDR_W-1:0] nw_ldaddr;
  logic [ADDR_W-1:0] nw_addr;
  logic              nw_halted, nw_stkerr;

  int checks;
  int passes;

  // Clock and reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  pc_seq #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RESET_ADDR(0), .WRAP(1), .STK_DEPTH(4)) dut (
    .Clk(Clk), .Clr(Clr), .Up(Up), .Ld(Ld), .LdAddr(LdAddr), .Br(Br), .BrOff(BrOff),
    .Call(Call), .Ret(Ret), .Addr(Addr), .Halted(Halted), .StkErr(StkErr)
  );

  pc_seq #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RESET_ADDR(0), .WRAP(0), .STK_DEPTH(4)) dut_nw (
    .Clk(Clk), .Clr(Clr), .Up(nw_up), .Ld(nw_ld), .LdAddr(nw_ldaddr), .Br(1'b0),
    .BrOff('0), .Call(1'b0), .Ret(1'b0), .Addr(nw_addr), .Halted(nw_halted),
    .StkErr(nw_stkerr)
  );

  // Driver tasks: inputs change just after the falling edge, outputs are
  // sampled at the next falling edge, well away from the rising edge.
  task automatic clear_inputs();
    Up = 0; Ld = 0; Br = 0; Call = 0; Ret = 0; LdAddr = '0; BrOff = '0;
    nw_up = 0; nw_ld = 0; nw_ldaddr = '0;
  endtask

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    clear_inputs();
    Ld = 1; LdAddr = a;
    cycle();
    clear_inputs();
  endtask

  task automatic pulse_clr();
    clear_inputs();
    #2 Clr = 1;
    #1 Clr = 0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Clr = 1;
    clear_inputs();
    repeat (2) @(negedge Clk);
    checks++; if (Addr !== 7'd0) $display("FAIL reset_addr got=%0d exp=0", Addr); else passes++;
    checks++; if (Halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", Halted); else passes++;
    checks++; if (StkErr !== 1'b0) $display("FAIL reset_stkerr got=%b exp=0", StkErr); else passes++;
    checks++; if (nw_addr !== 7'd0) $display("FAIL reset_nw_addr got=%0d exp=0", nw_addr); else passes++;
    Clr = 0;
    // Count up to 37, then assert Clr mid-cycle with no clock edge.
    Up = 1;
    repeat (37) cycle();
    checks++; if (Addr !== 7'd37) $display("FAIL count_37 got=%0d exp=37", Addr); else passes++;
    #2 Clr = 1;
    #1;
    checks++; if (Addr !== 7'd0) $display("FAIL async_clr_addr got=%0d exp=0", Addr); else passes++;
    checks++; if (Halted !== 1'b0) $display("FAIL async_clr_halted got=%b exp=0", Halted); else passes++;
    Up = 0;
    #1 Clr = 0;
    @(negedge Clk);
  endtask

  task automatic test_wrap();
    clear_inputs();
    Up = 1;
    repeat (127) cycle();
    checks++; if (Addr !== 7'd127) $display("FAIL wrap_127 got=%0d exp=127", Addr); else passes++;
    cycle();
    checks++; if (Addr !== 7'd0) $display("FAIL wrap_0 got=%0d exp=0", Addr); else passes++;
    cycle();
    checks++; if (Addr !== 7'd1) $display("FAIL wrap_1 got=%0d exp=1", Addr); else passes++;
    checks++; if (Halted !== 1'b0) $display("FAIL wrap_halted got=%b exp=0", Halted); else passes++;
    clear_inputs();
  endtask

  task automatic test_halt();
    clear_inputs();
    nw_up = 1;
    repeat (127) cycle();
    checks++; if (nw_addr !== 7'd127) $display("FAIL halt_reach got=%0d exp=127", nw_addr); else passes++;
    checks++; if (nw_halted !== 1'b0) $display("FAIL halt_early got=%b exp=0", nw_halted); else passes++;
    repeat (3) cycle();
    checks++; if (nw_addr !== 7'd127) $display("FAIL halt_hold got=%0d exp=127", nw_addr); else passes++;
    checks++; if (nw_halted !== 1'b1) $display("FAIL halt_flag got=%b exp=1", nw_halted); else passes++;
    nw_up = 0; nw_ld = 1; nw_ldaddr = 7'd10;
    cycle();
    checks++; if (nw_addr !== 7'd10) $display("FAIL halt_ld_addr got=%0d exp=10", nw_addr); else passes++;
    checks++; if (nw_halted !== 1'b0) $display("FAIL halt_ld_flag got=%b exp=0", nw_halted); else passes++;
    clear_inputs();
  endtask

  task automatic test_branch();
    load(7'd5);
    Br = 1; BrOff = 5'b11000;  // -8
    cycle();
    checks++; if (Addr !== 7'd125) $display("FAIL br_neg got=%0d exp=125", Addr); else passes++;
    load(7'd120);
    Br = 1; BrOff = 5'b01100;  // +12
    cycle();
    checks++; if (Addr !== 7'd4) $display("FAIL br_pos got=%0d exp=4", Addr); else passes++;
    Br = 1; BrOff = 5'b01111;  // +15
    cycle();
    checks++; if (Addr !== 7'd19) $display("FAIL br_max got=%0d exp=19", Addr); else passes++;
    clear_inputs();
  endtask

  task automatic test_priority();
    clear_inputs();
    Ld = 1; LdAddr = 7'd20; Br = 1; BrOff = 5'd3; Up = 1;
    cycle();
    checks++; if (Addr !== 7'd20) $display("FAIL prio_ld got=%0d exp=20", Addr); else passes++;
    Ld = 0;  // Br + Up together: branch wins
    cycle();
    checks++; if (Addr !== 7'd23) $display("FAIL prio_br got=%0d exp=23", Addr); else passes++;
    Br = 0;  // Up alone
    cycle();
    checks++; if (Addr !== 7'd24) $display("FAIL prio_up got=%0d exp=24", Addr); else passes++;
    Up = 0;  // nothing requested
    repeat (2) cycle();
    checks++; if (Addr !== 7'd24) $display("FAIL idle_hold got=%0d exp=24", Addr); else passes++;
  endtask

`ifdef PC_RET_STACK_EN
  task automatic test_stack();
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp;
    pulse_clr();
    load(7'd9);
    Call = 1; LdAddr = 7'd50;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd50) $display("FAIL call_addr got=%0d exp=50", Addr); else passes++;
    Ret = 1;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd10) $display("FAIL ret_addr got=%0d exp=10", Addr); else passes++;
    checks++; if (StkErr !== 1'b0) $display("FAIL ret_stkerr got=%b exp=0", StkErr); else passes++;
    // Five calls into a depth-4 stack: the fifth jumps but cannot push.
    exp_q = '{7'd11, 7'd61, 7'd62, 7'd63};
    for (int i = 0; i < 5; i++) begin
      Call = 1; LdAddr = 7'(60 + i);
      cycle();
      clear_inputs();
    end
    checks++; if (Addr !== 7'd64) $display("FAIL call5_addr got=%0d exp=64", Addr); else passes++;
    checks++; if (StkErr !== 1'b1) $display("FAIL call5_stkerr got=%b exp=1", StkErr); else passes++;
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_back();
      Ret = 1;
      cycle();
      clear_inputs();
      checks++; if (Addr !== exp) $display("FAIL ret_pop%0d got=%0d exp=%0d", i, Addr, exp); else passes++;
    end
    Ret = 1;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd11) $display("FAIL ret_empty_addr got=%0d exp=11", Addr); else passes++;
    checks++; if (StkErr !== 1'b1) $display("FAIL ret_empty_stkerr got=%b exp=1", StkErr); else passes++;
    pulse_clr();
    checks++; if (StkErr !== 1'b0) $display("FAIL clr_stkerr got=%b exp=0", StkErr); else passes++;
    // After Clr the stack is empty again: Ret is an error, not a pop.
    load(7'd30);
    Ret = 1;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd30) $display("FAIL clr_empty_addr got=%0d exp=30", Addr); else passes++;
    checks++; if (StkErr !== 1'b1) $display("FAIL clr_empty_err got=%b exp=1", StkErr); else passes++;
  endtask
`else
  task automatic test_stack();
    pulse_clr();
    load(7'd9);
    Call = 1; LdAddr = 7'd50;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd50) $display("FAIL call_as_ld got=%0d exp=50", Addr); else passes++;
    Ret = 1;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd50) $display("FAIL ret_ignored got=%0d exp=50", Addr); else passes++;
    checks++; if (StkErr !== 1'b0) $display("FAIL stkerr_tied got=%b exp=0", StkErr); else passes++;
    // Ret must not block a lower-priority jump when there is no stack.
    Ret = 1; Ld = 1; LdAddr = 7'd33;
    cycle();
    clear_inputs();
    checks++; if (Addr !== 7'd33) $display("FAIL ret_ld got=%0d exp=33", Addr); else passes++;
  endtask
`endif

  // Test sequence and final report
  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_wrap();
    test_halt();
    test_branch();
    test_priority();
    test_stack();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Run-time guard so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
